// File: rtl/run_seq_checker_if.sv
// Stream-checker bus: the sample input with its qualifier, the counter clear,
// and the registered status/pulse outputs of the checker.
interface run_seq_checker_if;
    logic       in_valid;
    logic [2:0] in_data;
    logic       clr_cnt;
    logic       locked;
    logic [2:0] exp_data;
    logic       run_done;
    logic       period_done;
    logic       err;
    logic [7:0] err_cnt;

    // Stimulus side: drives samples and the clear, observes status.
    modport master (
        output in_valid, in_data, clr_cnt,
        input  locked, exp_data, run_done, period_done, err, err_cnt
    );

    // Checker side.
    modport slave (
        input  in_valid, in_data, clr_cnt,
        output locked, exp_data, run_done, period_done, err, err_cnt
    );
endinterface

// File: rtl/run_seq_checker.sv
// Checker for the run stream 1,2,2,3,3,3,...,MAXV x MAXV,1,... (value k sent
// k times). Hunts for a 1 to synchronise, then tracks the expected value v and
// the repetition count r, flagging runs, periods and mismatches one cycle
// after the consuming edge. A mismatch that is itself a 1 resynchronises
// immediately instead of dropping back to hunting.
module run_seq_checker #(
    parameter int MAXV = 7
) (
    input logic           clk,
    input logic           rst,
    run_seq_checker_if.slave bus
);
    localparam logic [2:0] MAXV3 = 3'(MAXV);

    typedef enum logic {S_HUNT, S_LOCKED} state_t;

    state_t     state, state_n;
    logic [2:0] v, v_n;
    logic [2:0] r, r_n;
    logic       run_q, run_n;
    logic       per_q, per_n;
    logic       err_q, err_n;
    logic [7:0] cnt_q, cnt_n;

    // Next-state, pulse and counter decode for the sample presented this cycle.
    always_comb begin
        state_n = state;
        v_n     = v;
        r_n     = r;
        run_n   = 1'b0;
        per_n   = 1'b0;
        err_n   = 1'b0;
        cnt_n   = cnt_q;
        if (bus.in_valid) begin
            if (state == S_HUNT) begin
                // Only a 1 starts a stream; anything else is silently dropped.
                if (bus.in_data == 3'd1) begin
                    state_n = S_LOCKED;
                    v_n     = 3'd2;
                    r_n     = 3'd0;
                    run_n   = 1'b1;
                end
            end else if (bus.in_data == v) begin
                if (({1'b0, r} + 4'd1) < {1'b0, v}) begin
                    r_n = r + 3'd1;
                end else begin
                    run_n = 1'b1;
                    r_n   = 3'd0;
                    if (v < MAXV3) begin
                        v_n = v + 3'd1;
                    end else begin
                        v_n   = 3'd1;
                        per_n = 1'b1;
                    end
                end
            end else begin
                err_n = 1'b1;
                r_n   = 3'd0;
                if (bus.in_data == 3'd1) begin
                    // The offending sample is a valid run of 1: relock on it.
                    v_n   = 3'd2;
                    run_n = 1'b1;
                end else begin
                    state_n = S_HUNT;
                    v_n     = 3'd1;
                end
            end
        end
        // Clear wins over a coincident increment; the count saturates.
        if (bus.clr_cnt)
            cnt_n = 8'd0;
        else if (err_n && cnt_q != 8'hFF)
            cnt_n = cnt_q + 8'd1;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_HUNT;
            v     <= 3'd1;
            r     <= 3'd0;
            run_q <= 1'b0;
            per_q <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            state <= state_n;
            v     <= v_n;
            r     <= r_n;
            run_q <= run_n;
            per_q <= per_n;
            err_q <= err_n;
            cnt_q <= cnt_n;
        end
    end

    // Status is a direct view of the state registers.
    always_comb begin
        bus.locked      = (state == S_LOCKED);
        bus.exp_data    = v;
        bus.run_done    = run_q;
        bus.period_done = per_q;
        bus.err         = err_q;
        bus.err_cnt     = cnt_q;
    end
endmodule

// File: doc/run_seq_checker.md
RUN_SEQ_CHECKER -- requirements
Module: run_seq_checker

Interface
REQ-001 The parameter list SHALL be exactly: MAXV, default 7, highest run value before wrap (legal range 2..7).
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  asynchronous, active-low reset; rst=0 SHALL reset all state immediately, independent of clk.
REQ-004 Port in_valid  input  1  qualifies in_data; a sample SHALL be consumed only on a clk edge with in_valid=1.
REQ-005 Port in_data  input  3  received sample of the 1,2,2,3,3,3,... run stream (value k repeated k times, wrap MAXV->1).
REQ-006 Port clr_cnt  input  1  synchronous clear of err_cnt.
REQ-007 Port locked  output  1  1 = checker synchronised to stream.
REQ-008 Port exp_data  output  3  value expected in the next sample.
REQ-009 Port run_done  output  1  one-cycle pulse: a run of value k with exactly k samples completed.
REQ-010 Port period_done  output  1  one-cycle pulse: the run of value MAXV completed.
REQ-011 Port err  output  1  one-cycle pulse: consumed sample mismatched expectation while locked.
REQ-012 Port err_cnt  output  8  saturating count of err pulses.

Function
REQ-013 Internal state SHALL be two-state FSM {HUNT, LOCKED}, expected value v (3 bits), repetition count r (3 bits, 0..v-1).
REQ-014 All outputs SHALL be registered; every pulse SHALL appear in the cycle after the clk edge that consumed the sample (latency 1).
REQ-015 With in_valid=0, FSM, v, r, locked, exp_data and err_cnt SHALL hold, and run_done/period_done/err SHALL be 0.
REQ-016 HUNT: sample in_data=1 SHALL give LOCKED, v=2, r=0, run_done=1; any other sample SHALL be discarded with no err.
REQ-017 HUNT: locked SHALL be 0 and exp_data SHALL be 1.
REQ-018 LOCKED, in_data==v, r+1<v: r SHALL increment; no pulse.
REQ-019 LOCKED, in_data==v, r+1==v: run_done=1, r=0; v=v+1 if v<MAXV, else v=1 with period_done=1.
REQ-020 LOCKED, in_data!=v and in_data!=1: err=1, err_cnt+1, state HUNT, v=1, r=0.
REQ-021 LOCKED, in_data!=v and in_data==1: err=1, err_cnt+1, resync in the same cycle: stay LOCKED, v=2, r=0, run_done=1.
REQ-022 After wrap (v=1 expected), sample 1 SHALL complete its run per REQ-019 with no err.
REQ-023 err_cnt SHALL saturate at 255 and not wrap.
REQ-024 clr_cnt=1 SHALL set err_cnt to 0 and SHALL take priority over a simultaneous increment; err pulse still fires.
REQ-025 locked SHALL equal (state==LOCKED) and exp_data SHALL equal v at all times.
REQ-026 in_data values 0 or >MAXV SHALL be treated as mismatches per REQ-020/REQ-016.

Reset
REQ-027 While rst=0: state HUNT, v=1, r=0, locked=0, exp_data=1, run_done=0, period_done=0, err=0, err_cnt=0.
REQ-028 rst asserted mid-run SHALL abandon the run; after release, the checker SHALL re-hunt for a 1.

Verification
REQ-029 Reset, then continuous stream 1,2,2,3,3,3,...,7x7,1 (29 samples) -> locked=1 after sample 1, 8 run_done pulses, period_done once after sample 28, err never 1, exp_data=2 at end.
REQ-030 Same stream with in_valid=0 gaps of 1-3 cycles between samples -> identical pulse sequence and final state as REQ-029.
REQ-031 Locked, send 1,2,3 -> err pulse after the 3, err_cnt=1, locked=0, exp_data=1; next sample 1 -> locked=1, exp_data=2.
REQ-032 Locked, mid-run 4,4 then 1 -> err=1 and run_done=1 in same cycle, err_cnt increments, locked stays 1, exp_data=2.
REQ-033 Repeat 260 mismatches (alternating 1,5 from lock) -> err_cnt=255; clr_cnt=1 coincident with an err -> err_cnt=0.
REQ-034 rst=0 between clk edges during a run of 5s -> all outputs reach reset values before the next edge; stream resumes with 5s -> locked stays 0.
